zero_det_arbiter: RTL

- Shares one serial zero-detection datapath between two requesters.
- Round-robin arbiter accepts one parallel word at a time and serializes it LSB-first into an internal Mealy zero detector.
- Counts detector hits and returns the count tagged with the requester ID.
- Sits between parallel producers and the bit-serial detection logic; sequences load, shift and report phases.

---
 rtl/zero_det_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/zero_det_arbiter.sv
// rtl/zero_det_arbiter.sv - round-robin arbiter feeding two requesters' words into a shared serial zero detector
// Serializes the granted word LSB-first and counts zero bits, excluding the first bit of each word.
module zero_det_arbiter #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             x_ser,
   output logic             done,
   output logic             done_id,
   output logic [CW-1:0]    zero_cnt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [IW-1:0]    idx, idx_n;
   logic [CW-1:0]    acc, acc_n;
   logic             owner, owner_n;
   logic             last, last_n;
   logic             gnt0_n, gnt1_n, busy_n, done_n, done_id_n;
   logic [CW-1:0]    zero_cnt_n;
   logic             pick;
   logic             hit;

   // x_ser comes straight off the shift register flop
   assign x_ser = shreg[0];

   // Contention goes to whoever was not served last; last resets to 1 so requester 0 wins first
   assign pick = (req0 && req1) ? ~last : req1;
   assign hit  = ~shreg[0] && (idx != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shreg    <= '0;
         idx      <= '0;
         acc      <= '0;
         owner    <= 1'b0;
         last     <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         done_id  <= 1'b0;
         zero_cnt <= '0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         idx      <= idx_n;
         acc      <= acc_n;
         owner    <= owner_n;
         last     <= last_n;
         gnt0     <= gnt0_n;
         gnt1     <= gnt1_n;
         busy     <= busy_n;
         done     <= done_n;
         done_id  <= done_id_n;
         zero_cnt <= zero_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      idx_n      = idx;
      acc_n      = acc;
      owner_n    = owner;
      last_n     = last;
      gnt0_n     = 1'b0;
      gnt1_n     = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
      done_id_n  = done_id;
      zero_cnt_n = zero_cnt;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               shreg_n = pick ? data1 : data0;
               idx_n   = '0;
               acc_n   = '0;
               owner_n = pick;
               last_n  = pick;
               gnt0_n  = ~pick;
               gnt1_n  = pick;
               busy_n  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            busy_n  = 1'b1;
            acc_n   = acc + CW'(hit);
            shreg_n = shreg >> 1;
            idx_n   = idx + 1'b1;
            if (idx == LAST_IDX) begin
               zero_cnt_n = acc + CW'(hit);
               done_id_n  = owner;
               done_n     = 1'b1;
               state_n    = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
